uart_receiver_ext: RTL and testbench

Next-generation UART receiver for the IO subsystem. It extends the fixed 8N1 receiver with run-time configurable data width, parity and stop bits, and a false-start filter. It adds per-frame framing and parity error flags and a small receive FIFO with overrun detection. It sits between the serial_in pad and the memory-mapped UART register block, and shares the same runtime baud_edge divisor input.

---
 rtl/uart_receiver_ext.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_uart_receiver_ext.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_ext.sv
// uart_receiver_ext
// Configurable UART receiver. It supports 5..DATA_BITS data bits, optional
// even/odd parity, one or two stop bits, and a false-start filter. Received
// frames go into a small FIFO together with their framing and parity error
// flags. A sticky overrun flag records frames that were dropped.
//
// Optional feature: define UART_RX_BREAK_EN to add break detection. This
// adds the break_det output and a BREAK state that waits for the line to
// return to idle.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   baud_edge      clocks per bit (>= 4), stable during a frame
//   data_len       00=5, 01=6, 10=7, 11=DATA_BITS data bits
//   parity_mode    00/11=none, 01=even, 10=odd
//   stop_bits      0=one, 1=two stop bits
//   serial_in      asynchronous RX line, idle high
//   data_out       FIFO head data, LSB-aligned
//   frame_err      FIFO head framing error flag
//   parity_err     FIFO head parity error flag
//   data_out_valid FIFO non-empty
//   data_out_ready consumer pop strobe
//   overrun        sticky dropped-frame flag, cleared by a pop
//   fifo_count     FIFO occupancy
//   break_det      (UART_RX_BREAK_EN only) one-cycle break pulse
module uart_receiver_ext #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int MIN_BDRT   = 9_600,
    parameter int BAUD_BITS  = $clog2((CLOCK_FREQ + (MIN_BDRT / 2) - 1) / (MIN_BDRT / 2)),
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [BAUD_BITS-1:0]            baud_edge,
    input  logic [1:0]                      data_len,
    input  logic [1:0]                      parity_mode,
    input  logic                            stop_bits,
    input  logic                            serial_in,
    output logic [DATA_BITS-1:0]            data_out,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic                            overrun,
`ifdef UART_RX_BREAK_EN
    output logic                            break_det,
`endif
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = 4;
    localparam int ENT_W = DATA_BITS + 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
`ifdef UART_RX_BREAK_EN
        ST_BREAK  = 3'd5,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // XOR of the received data bits; unused upper bits are always zero.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    logic                 sync1_r, sync2_r, rx_s;
    state_t               state_r;
    logic [BAUD_BITS-1:0] cnt_r;
    logic [IDX_W-1:0]     bit_idx_r, len_r, len_cfg_s;
    logic                 par_en_r, par_odd_r, stop2_r, stop_idx_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 ferr_r, perr_r;
    logic                 sample_s, edge_s, push_s, pop_s, full_s, wr_en_s;
    logic [ENT_W-1:0]     push_entry_s, head_s;
    logic [ENT_W-1:0]     mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 overrun_r;
`ifdef UART_RX_BREAK_EN
    logic                 par_bit_r, brk_s, break_det_r;
`endif

    assign rx_s     = sync2_r;
    assign sample_s = (cnt_r == (baud_edge >> 1));
    assign edge_s   = (cnt_r == (baud_edge - BAUD_BITS'(1)));
    assign pop_s    = (count_r != {CNT_W{1'b0}}) && data_out_ready;
    assign full_s   = (count_r == CNT_W'(FIFO_DEPTH));
    // Push while full goes ahead only if the head is leaving in the same cycle.
    assign wr_en_s  = push_s && (!full_s || pop_s);

    // Two-flop synchroniser for the asynchronous RX line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= serial_in;
            sync2_r <= sync1_r;
        end
    end

    // Decode the data_len code into a bit count.
    always_comb begin
        case (data_len)
            2'b00:   len_cfg_s = 4'd5;
            2'b01:   len_cfg_s = 4'd6;
            2'b10:   len_cfg_s = 4'd7;
            default: len_cfg_s = IDX_W'(DATA_BITS);
        endcase
    end

    // Decide whether this cycle pushes a frame and build the FIFO entry.
    always_comb begin
        push_s       = 1'b0;
        push_entry_s = {ENT_W{1'b0}};
`ifdef UART_RX_BREAK_EN
        brk_s        = 1'b0;
`endif
        if (state_r == ST_STOP && sample_s) begin
`ifdef UART_RX_BREAK_EN
            // All-zero data, zero parity bit and a low first stop bit form a break.
            if (!stop_idx_r && !rx_s && (data_r == {DATA_BITS{1'b0}}) && !(par_en_r && par_bit_r)) begin
                brk_s        = 1'b1;
                push_s       = 1'b1;
                push_entry_s = {perr_r, 1'b1, data_r};
            end else if (stop_idx_r == stop2_r) begin
                push_s       = 1'b1;
                push_entry_s = {perr_r, ferr_r | ~rx_s, data_r};
            end else begin
                push_s       = 1'b0;
            end
`else
            if (stop_idx_r == stop2_r) begin
                push_s       = 1'b1;
                push_entry_s = {perr_r, ferr_r | ~rx_s, data_r};
            end else begin
                push_s       = 1'b0;
            end
`endif
        end else begin
            push_s = 1'b0;
        end
    end

    // Receive FSM with bit timer, frame shift register and error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {BAUD_BITS{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            len_r      <= {IDX_W{1'b0}};
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
            stop2_r    <= 1'b0;
            stop_idx_r <= 1'b0;
            data_r     <= {DATA_BITS{1'b0}};
            ferr_r     <= 1'b0;
            perr_r     <= 1'b0;
`ifdef UART_RX_BREAK_EN
            par_bit_r   <= 1'b0;
            break_det_r <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_BREAK_EN
            break_det_r <= brk_s;
`endif
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {BAUD_BITS{1'b0}};
                    if (!rx_s) begin
                        // Frame format is frozen for the whole frame here.
                        len_r      <= len_cfg_s;
                        par_en_r   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        par_odd_r  <= (parity_mode == 2'b10);
                        stop2_r    <= stop_bits;
                        bit_idx_r  <= {IDX_W{1'b0}};
                        stop_idx_r <= 1'b0;
                        data_r     <= {DATA_BITS{1'b0}};
                        ferr_r     <= 1'b0;
                        perr_r     <= 1'b0;
`ifdef UART_RX_BREAK_EN
                        par_bit_r  <= 1'b0;
`endif
                        state_r    <= ST_START;
                    end
                end
                ST_START: begin
                    cnt_r <= edge_s ? {BAUD_BITS{1'b0}} : cnt_r + BAUD_BITS'(1);
                    if (sample_s && rx_s) begin
                        state_r <= ST_IDLE;
                    end else if (edge_s) begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    cnt_r <= edge_s ? {BAUD_BITS{1'b0}} : cnt_r + BAUD_BITS'(1);
                    if (sample_s) begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bit_idx_r == IDX_W'(i)) begin
                                data_r[i] <= rx_s;
                            end
                        end
                    end
                    if (edge_s) begin
                        if (bit_idx_r == len_r - IDX_W'(1)) begin
                            state_r <= par_en_r ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    cnt_r <= edge_s ? {BAUD_BITS{1'b0}} : cnt_r + BAUD_BITS'(1);
                    if (sample_s) begin
                        // Even: data^parity must be 0; odd: must be 1.
                        perr_r <= calc_parity(data_r) ^ rx_s ^ par_odd_r;
`ifdef UART_RX_BREAK_EN
                        par_bit_r <= rx_s;
`endif
                    end
                    if (edge_s) begin
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    cnt_r <= edge_s ? {BAUD_BITS{1'b0}} : cnt_r + BAUD_BITS'(1);
                    if (sample_s) begin
`ifdef UART_RX_BREAK_EN
                        if (brk_s) begin
                            state_r <= ST_BREAK;
                            cnt_r   <= {BAUD_BITS{1'b0}};
                        end else if (push_s) begin
                            state_r <= ST_IDLE;
                        end else if (!rx_s) begin
                            ferr_r <= 1'b1;
                        end
`else
                        // Leaving at the final stop sample re-arms half a bit early.
                        if (push_s) begin
                            state_r <= ST_IDLE;
                        end else if (!rx_s) begin
                            ferr_r <= 1'b1;
                        end
`endif
                    end
                    if (edge_s) begin
                        stop_idx_r <= 1'b1;
                    end
                end
`ifdef UART_RX_BREAK_EN
                ST_BREAK: begin
                    // Count consecutive high cycles; one full bit time re-arms.
                    if (!rx_s) begin
                        cnt_r <= {BAUD_BITS{1'b0}};
                    end else if (edge_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + BAUD_BITS'(1);
                    end
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Receive FIFO storage, pointers, occupancy and sticky overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ENT_W{1'b0}};
            end
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (pop_s) begin
                overrun_r <= 1'b0;
            end else if (push_s && !wr_en_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign head_s         = mem_r[rd_ptr_r];
    assign data_out       = head_s[DATA_BITS-1:0];
    assign frame_err      = head_s[DATA_BITS];
    assign parity_err     = head_s[DATA_BITS+1];
    assign data_out_valid = (count_r != {CNT_W{1'b0}});
    assign overrun        = overrun_r;
    assign fifo_count     = count_r;
`ifdef UART_RX_BREAK_EN
    assign break_det      = break_det_r;
`endif

endmodule

// File: tb/tb_uart_receiver_ext.sv
// Self-checking bench for uart_receiver_ext: a directed vector table,
// hand-written corner sequences and randomized frames against a queue model.
module tb_uart_receiver_ext;

    localparam int DB = 8;
    localparam int FD = 4;
    localparam int BB = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [BB-1:0] baud_edge;
    logic [1:0]    data_len, parity_mode;
    logic          stop_bits, serial_in, data_out_ready;
    logic [DB-1:0] data_out;
    logic          frame_err, parity_err, data_out_valid, overrun;
    logic [2:0]    fifo_count;
`ifdef UART_RX_BREAK_EN
    logic          break_det;
    int            brk_pulses = 0;
`endif

    uart_receiver_ext #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .baud_edge(baud_edge), .data_len(data_len),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .serial_in(serial_in),
        .data_out(data_out), .frame_err(frame_err), .parity_err(parity_err),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .overrun(overrun),
`ifdef UART_RX_BREAK_EN
        .break_det(break_det),
`endif
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

`ifdef UART_RX_BREAK_EN
    always @(posedge clk) if (break_det) brk_pulses++;
`endif

    int vectors = 0;
    int miscompares = 0;
    int be = 16;

    typedef struct {
        logic [7:0] din;
        logic [1:0] len;
        logic [1:0] pm;
        logic       s2;
        logic       flip;
        logic [1:0] stops;
        logic [7:0] exp_d;
        logic       exp_f;
        logic       exp_p;
    } vec_t;

    typedef struct { logic [7:0] d; logic f; logic p; } ent_t;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int nbits_of(input logic [1:0] len);
        return (len == 2'd3) ? DB : 5 + int'(len);
    endfunction

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (be) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        serial_in = 1'b1;
        repeat (n * be) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                              input logic pbit, input logic s2, input logic [1:0] stops);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (par_en) drive_bit(pbit);
        drive_bit(stops[0]);
        if (s2) drive_bit(stops[1]);
    endtask

    task automatic pop();
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] len, input logic [1:0] pm, input logic s2);
        data_len = len; parity_mode = pm; stop_bits = s2; baud_edge = BB'(be);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, int'(data_out), 0);
        chk({tag, "_ferr"}, int'(frame_err), 0);
        chk({tag, "_perr"}, int'(parity_err), 0);
        chk({tag, "_valid"}, int'(data_out_valid), 0);
        chk({tag, "_ovr"}, int'(overrun), 0);
        chk({tag, "_count"}, int'(fifo_count), 0);
    endtask

    vec_t tbl[9];
    ent_t q[$];

    initial begin
        logic [7:0] d, dm, mask;
        logic [1:0] len, pm, stops;
        logic s2, par_en, pbit, ov_exp, flip;
        int nb, gap;
        ent_t e;

        tbl[0] = '{8'h5A, 2'd3, 2'd0, 1'b0, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0};
        tbl[1] = '{8'h41, 2'd2, 2'd2, 1'b1, 1'b0, 2'b11, 8'h41, 1'b0, 1'b0};
        tbl[2] = '{8'h41, 2'd2, 2'd2, 1'b1, 1'b1, 2'b11, 8'h41, 1'b0, 1'b1};
        tbl[3] = '{8'h33, 2'd3, 2'd0, 1'b1, 1'b0, 2'b01, 8'h33, 1'b1, 1'b0};
        tbl[4] = '{8'h1F, 2'd0, 2'd1, 1'b0, 1'b0, 2'b11, 8'h1F, 1'b0, 1'b0};
        tbl[5] = '{8'hA6, 2'd1, 2'd0, 1'b0, 1'b0, 2'b10, 8'h26, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 2'd3, 2'd1, 1'b0, 1'b1, 2'b11, 8'h80, 1'b0, 1'b1};
        tbl[7] = '{8'h00, 2'd3, 2'd2, 1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 1'b0};
        tbl[8] = '{8'hFF, 2'd2, 2'd3, 1'b0, 1'b0, 2'b11, 8'h7F, 1'b0, 1'b0};

        // Reset state
        reset_n = 1'b0; serial_in = 1'b1; data_out_ready = 1'b0;
        set_cfg(2'd3, 2'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // False start: 6 low clocks then high
        serial_in = 1'b0;
        repeat (6) @(negedge clk);
        serial_in = 1'b1;
        repeat (3 * be) @(negedge clk);
        chk("false_start_count", int'(fifo_count), 0);
        chk("false_start_valid", int'(data_out_valid), 0);

        // Directed vector table
        for (int k = 0; k < 9; k++) begin
            set_cfg(tbl[k].len, tbl[k].pm, tbl[k].s2);
            nb = nbits_of(tbl[k].len);
            mask = 8'((1 << nb) - 1);
            dm = tbl[k].din & mask;
            par_en = (tbl[k].pm == 2'd1) || (tbl[k].pm == 2'd2);
            pbit = ((tbl[k].pm == 2'd1) ? ^dm : ~^dm) ^ tbl[k].flip;
            send_frame(tbl[k].din, nb, par_en, pbit, tbl[k].s2, tbl[k].stops);
            idle_bits(2);
            chk($sformatf("tbl%0d_count", k), int'(fifo_count), 1);
            chk($sformatf("tbl%0d_valid", k), int'(data_out_valid), 1);
            chk($sformatf("tbl%0d_data", k), int'(data_out), int'(tbl[k].exp_d));
            chk($sformatf("tbl%0d_ferr", k), int'(frame_err), int'(tbl[k].exp_f));
            chk($sformatf("tbl%0d_perr", k), int'(parity_err), int'(tbl[k].exp_p));
            pop();
            chk($sformatf("tbl%0d_count_after_pop", k), int'(fifo_count), 0);
        end

        // Overrun: 5 back-to-back frames, ready low
        set_cfg(2'd3, 2'd0, 1'b0);
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 8, 1'b0, 1'b0, 1'b0, 2'b11);
        idle_bits(2);
        chk("ovr_count", int'(fifo_count), 4);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_head", int'(data_out), 1);
        pop();
        chk("ovr_flag_cleared", int'(overrun), 0);
        for (int k = 2; k <= 4; k++) begin
            chk($sformatf("ovr_head%0d", k), int'(data_out), k);
            pop();
        end
        chk("ovr_drained", int'(fifo_count), 0);

        // Second stop low, then reset mid-frame
        set_cfg(2'd3, 2'd0, 1'b1);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 2'b01);
        idle_bits(1);
        chk("s2low_data", int'(data_out), 8'h33);
        chk("s2low_ferr", int'(frame_err), 1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30 * be) @(negedge clk);
        chk("midreset_nopush", int'(fifo_count), 0);

`ifdef UART_RX_BREAK_EN
        // Break: line low for 3 frame times, short high glitch, low again
        set_cfg(2'd3, 2'd0, 1'b0);
        brk_pulses = 0;
        serial_in = 1'b0;
        repeat (30 * be) @(negedge clk);
        serial_in = 1'b1;
        repeat (be / 2) @(negedge clk);
        serial_in = 1'b0;
        repeat (10 * be) @(negedge clk);
        idle_bits(2);
        chk("brk_count", int'(fifo_count), 1);
        chk("brk_data", int'(data_out), 0);
        chk("brk_ferr", int'(frame_err), 1);
        chk("brk_pulses", brk_pulses, 1);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 2'b11);
        idle_bits(2);
        chk("brk_rearm_count", int'(fifo_count), 2);
        pop();
        chk("brk_rearm_data", int'(data_out), 8'h5A);
        pop();
`endif

        // Randomized frames against a queue model
        q.delete();
        ov_exp = 1'b0;
        be = $urandom_range(4, 24);
        baud_edge = BB'(be);
        for (int n = 0; n < 40; n++) begin
            len = 2'($urandom_range(0, 3));
            pm = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            stops[0] = ($urandom_range(0, 3) != 0);
            stops[1] = ($urandom_range(0, 3) != 0);
            nb = nbits_of(len);
            mask = 8'((1 << nb) - 1);
            dm = d & mask;
            par_en = (pm == 2'd1) || (pm == 2'd2);
            pbit = ((pm == 2'd1) ? ^dm : ~^dm) ^ flip;
            if (dm == 8'h00 && !stops[0] && (!par_en || !pbit)) stops[0] = 1'b1;
            set_cfg(len, pm, s2);
            e.d = dm;
            e.f = !stops[0] || (s2 && !stops[1]);
            e.p = (pm == 2'd1) ? (^dm ^ pbit) : (pm == 2'd2) ? ~(^dm ^ pbit) : 1'b0;
            if (q.size() < FD) q.push_back(e);
            else ov_exp = 1'b1;
            send_frame(d, nb, par_en, pbit, s2, stops);
            gap = (!(s2 ? stops[1] : stops[0])) ? $urandom_range(1, 2) : $urandom_range(0, 2);
            idle_bits(gap);
            if (($urandom_range(0, 2) == 0) || (n == 39)) begin
                idle_bits(2);
                chk("rnd_count", int'(fifo_count), q.size());
                chk("rnd_overrun", int'(overrun), int'(ov_exp));
                while (q.size() > 0) begin
                    chk("rnd_data", int'(data_out), int'(q[0].d));
                    chk("rnd_ferr", int'(frame_err), int'(q[0].f));
                    chk("rnd_perr", int'(parity_err), int'(q[0].p));
                    pop();
                    void'(q.pop_front());
                    ov_exp = 1'b0;
                    chk("rnd_overrun_after_pop", int'(overrun), 0);
                end
                chk("rnd_empty", int'(data_out_valid), 0);
                be = $urandom_range(4, 24);
                baud_edge = BB'(be);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
